// File: rtl/seq_divider_if.sv
// Handshake and operand/result bundle for seq_divider.
// master: drives start/dividend/divisor, observes busy/done/results.
// slave : the divider itself.
//   start       request pulse, honoured only while idle
//   dividend    unsigned numerator, sampled on an accepted start
//   divisor     unsigned denominator, sampled on an accepted start
//   busy        division in progress
//   done        one-cycle completion pulse
//   quotient    registered quotient, held until the next completion
//   remainder   registered remainder, held until the next completion
//   div_by_zero set with done when the divisor was zero
interface seq_divider_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per clock.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    seq_divider_if.slave: start/dividend/divisor in,
//          busy/done/quotient/remainder/div_by_zero out (all registered)
// A normal divide completes WIDTH cycles after the accepting edge; a zero
// divisor completes after one cycle with quotient all ones and
// remainder equal to the dividend.
module seq_divider #(
  parameter int unsigned WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  q_q, q_d;
  // Partial remainder is always < D after each step, so WIDTH bits suffice
  // for storage; only the shifted trial value needs the extra bit.
  logic [WIDTH-1:0]  r_q, r_d;
  logic [WIDTH-1:0]  d_q, d_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  quot_q, quot_d;
  logic [WIDTH-1:0]  rem_q, rem_d;
  logic              dbz_q, dbz_d;

  logic [WIDTH:0]    r_shift;
  logic              fits;
  logic [WIDTH-1:0]  r_next;
  logic [WIDTH-1:0]  q_next;

  always_comb begin
    r_shift = {r_q, q_q[WIDTH-1]};
    fits    = (r_shift >= {1'b0, d_q});
    // When the trial fits, the difference is < D, so a WIDTH-bit subtract is exact.
    r_next  = fits ? (r_shift[WIDTH-1:0] - d_q) : r_shift[WIDTH-1:0];
    q_next  = {q_q[WIDTH-2:0], fits};
  end

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    q_d     = q_q;
    r_d     = r_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;

    case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StRun;
          busy_d  = 1'b1;
          q_d     = bus.dividend;
          d_d     = bus.divisor;
          r_d     = '0;
          cnt_d   = CntW'(WIDTH);
          dbz_d   = 1'b0;
        end
      end
      StRun: begin
        if (d_q == '0) begin
          // Q still holds the untouched dividend here.
          quot_d  = '1;
          rem_d   = q_q;
          dbz_d   = 1'b1;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          q_d   = q_next;
          r_d   = r_next;
          cnt_d = cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            quot_d  = q_next;
            rem_d   = r_next;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      q_q     <= q_d;
      r_q     <= r_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.quotient    = quot_q;
  assign bus.remainder   = rem_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider (WIDTH=4). Inputs are driven 1 time unit
// after a rising edge and outputs are sampled at the same point.
module tb_seq_divider;

  localparam int unsigned W = 4;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_divider_if #(.WIDTH(W)) dif ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands with start high; the next rising edge accepts them.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dif.start    = 1'b1;
    dif.dividend = a;
    dif.divisor  = b;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk("busy_at_accept", {31'd0, dif.busy}, 32'd1);
    chk("done_low_at_accept", {31'd0, dif.done}, 32'd0);
  endtask

  // Cycles from the accepting edge until done, bounded.
  task automatic wait_done(input int start_lat, output int lat, output bit busy_ok);
    lat     = start_lat;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!dif.done && !dif.busy) busy_ok = 1'b0;
    end while (!dif.done && lat < 50);
    chk("done_seen", {31'd0, dif.done}, 32'd1);
  endtask

  task automatic check_res(input string tag, input int lat, input int exp_lat, input bit busy_ok,
                           input int eq, input int er, input int ez);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_held"}, {31'd0, busy_ok}, 32'd1);
    chk({tag, "_busy_falls"}, {31'd0, dif.busy}, 32'd0);
    chk({tag, "_quotient"}, {28'd0, dif.quotient}, eq);
    chk({tag, "_remainder"}, {28'd0, dif.remainder}, er);
    chk({tag, "_dbz"}, {31'd0, dif.div_by_zero}, ez);
  endtask

  initial begin
    int lat;
    bit busy_ok;
    int n_done;
    errors       = 0;
    checks       = 0;
    rst_n        = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;

    #2 rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_busy", {31'd0, dif.busy}, 32'd0);
    chk("rst_done", {31'd0, dif.done}, 32'd0);
    chk("rst_quotient", {28'd0, dif.quotient}, 32'd0);
    chk("rst_remainder", {28'd0, dif.remainder}, 32'd0);
    chk("rst_dbz", {31'd0, dif.div_by_zero}, 32'd0);
    rst_n = 1'b1;

    // 13 / 3 = 4 r 1
    launch(4'd13, 4'd3);
    wait_done(0, lat, busy_ok);
    check_res("d13_3", lat, 4, busy_ok, 4, 1, 0);
    @(posedge clk);
    #1;
    chk("done_one_cycle", {31'd0, dif.done}, 32'd0);
    chk("quotient_held", {28'd0, dif.quotient}, 32'd4);

    // 5 / 0, then 15 / 1
    launch(4'd5, 4'd0);
    wait_done(0, lat, busy_ok);
    check_res("d5_0", lat, 1, busy_ok, 15, 5, 1);
    @(posedge clk);
    #1;
    launch(4'd15, 4'd1);
    chk("dbz_cleared_at_accept", {31'd0, dif.div_by_zero}, 32'd0);
    chk("rem_held_until_done", {28'd0, dif.remainder}, 32'd5);
    wait_done(0, lat, busy_ok);
    check_res("d15_1", lat, 4, busy_ok, 15, 0, 0);

    // Back-to-back: 2/7 then 15/15 started in the done cycle
    @(posedge clk);
    #1;
    launch(4'd2, 4'd7);
    wait_done(0, lat, busy_ok);
    check_res("d2_7", lat, 4, busy_ok, 0, 2, 0);
    launch(4'd15, 4'd15);
    wait_done(0, lat, busy_ok);
    check_res("d15_15", lat, 4, busy_ok, 1, 0, 0);

    // 9 / 2 with an ignored start (8 / 4) presented at E2
    @(posedge clk);
    #1;
    launch(4'd9, 4'd2);
    @(posedge clk);
    #1;
    dif.start    = 1'b1;
    dif.dividend = 4'd8;
    dif.divisor  = 4'd4;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    chk("ignored_start_busy", {31'd0, dif.busy}, 32'd1);
    wait_done(2, lat, busy_ok);
    check_res("d9_2", lat, 4, busy_ok, 4, 1, 0);
    n_done = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      if (dif.done) n_done++;
    end
    chk("ignored_start_no_extra_done", n_done, 0);
    chk("ignored_start_idle", {31'd0, dif.busy}, 32'd0);

    // Reset in the middle of 12 / 5
    launch(4'd12, 4'd5);
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", {31'd0, dif.busy}, 32'd0);
    chk("midrst_quotient", {28'd0, dif.quotient}, 32'd0);
    chk("midrst_remainder", {28'd0, dif.remainder}, 32'd0);
    chk("midrst_dbz", {31'd0, dif.div_by_zero}, 32'd0);
    n_done = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      if (dif.done || dif.busy) n_done++;
    end
    chk("midrst_no_activity", n_done, 0);
    rst_n = 1'b1;
    launch(4'd12, 4'd5);
    wait_done(0, lat, busy_ok);
    check_res("d12_5", lat, 4, busy_ok, 2, 2, 0);

    // Exhaustive sweep, each start issued in the previous done cycle
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        launch(W'(a), W'(b));
        wait_done(0, lat, busy_ok);
        if (b == 0) begin
          check_res("sweep_dz", lat, 1, busy_ok, 15, a, 0 + 1);
        end else begin
          chk("sweep_latency", lat, 4);
          chk("sweep_identity", int'(dif.quotient) * b + int'(dif.remainder), a);
          chk("sweep_rem_lt_div", {31'd0, (int'(dif.remainder) < b)}, 32'd1);
          chk("sweep_dbz", {31'd0, dif.div_by_zero}, 32'd0);
        end
      end
    end
    @(posedge clk);
    #1;
    chk("sweep_single_done", {31'd0, dif.done}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
